// File: rtl/alarm_clock_pkg.sv
// Shared encodings and field limits for the alarm clock datapath.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    FS_MIN  = 2'b00,
    FS_HOUR = 2'b01,
    FS_DAY  = 2'b10,
    FS_NONE = 2'b11
  } field_sel_t;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;
  localparam int DAY_MAX  = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RING   = 2'b01,
    ST_SNOOZE = 2'b10
  } alarm_state_t;

endpackage

// File: rtl/time_alarm_datapath_if.sv
// Control inputs from control_unit_1 and time/alarm/buzzer outputs of the datapath.
interface time_alarm_datapath_if;

  logic       Tick;
  logic       SetMode;
  logic       Incr;
  logic [1:0] FieldSel;
  logic       Target;
  logic       ClearSec;
  logic       AlarmEn;
  logic       AlarmAck;
  logic       Snooze;

  logic [5:0] Sec;
  logic [5:0] Min;
  logic [4:0] Hour;
  logic [2:0] Day;
  logic [5:0] AlMin;
  logic [4:0] AlHour;
  logic       Ring;
  logic       Snoozing;

  modport master (
    output Tick, SetMode, Incr, FieldSel, Target, ClearSec, AlarmEn, AlarmAck, Snooze,
    input  Sec, Min, Hour, Day, AlMin, AlHour, Ring, Snoozing
  );

  modport slave (
    input  Tick, SetMode, Incr, FieldSel, Target, ClearSec, AlarmEn, AlarmAck, Snooze,
    output Sec, Min, Hour, Day, AlMin, AlHour, Ring, Snoozing
  );

endinterface

// File: rtl/mod_n_counter.sv
// Modulo-N up-counter with clear; wrap is combinational so carry chains settle in one edge.
module mod_n_counter #(
  parameter int N     = 60,
  parameter int WIDTH = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

  assign wrap = inc && !clr && (value == LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= wrap ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/time_alarm_datapath.sv
// Time-of-day and alarm registers plus the ring/snooze sequencer feeding display and buzzer.
//
// state     | meaning
// ST_IDLE   | buzzer off, waiting for a registered alarm match
// ST_RING   | buzzer on, counting ticks toward auto-stop
// ST_SNOOZE | buzzer off, counting minute rollovers toward re-ring
module time_alarm_datapath
  import alarm_clock_pkg::*;
#(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input logic                  Clk,
  input logic                  Reset,
  time_alarm_datapath_if.slave bus
);

  localparam logic [7:0] RING_LAST   = 8'(RING_SECS);
  localparam logic [3:0] SNOOZE_LAST = 4'(SNOOZE_MIN);

  logic       run_mode;
  logic       set_inc;
  logic       sec_inc;
  logic       inc_min, inc_hour, inc_day;
  logic       inc_al_min, inc_al_hour;
  logic       sec_wrap, min_wrap, hour_wrap;
  logic       unused_day_wrap, unused_al_min_wrap, unused_al_hour_wrap;

  logic [5:0] sec_q, min_q, al_min_q;
  logic [4:0] hour_q, al_hour_q;
  logic [2:0] day_q;

  logic [5:0] min_next;
  logic [4:0] hour_next;
  logic       match_d, match_q;

  alarm_state_t state_q, state_d;
  logic [7:0]   ring_cnt_q, ring_cnt_d;
  logic [3:0]   snz_cnt_q, snz_cnt_d;
  logic         ring, snoozing;

  assign run_mode = !bus.SetMode;
  assign set_inc  = bus.SetMode && bus.Incr;
  assign sec_inc  = run_mode && bus.Tick && !bus.ClearSec;

  // In set mode a field wraps on its own; carries only propagate while running.
  assign inc_min     = sec_wrap
                     || (set_inc && !bus.Target && bus.FieldSel == FS_MIN);
  assign inc_hour    = (run_mode && min_wrap)
                     || (set_inc && !bus.Target && bus.FieldSel == FS_HOUR);
  assign inc_day     = (run_mode && hour_wrap)
                     || (set_inc && !bus.Target && bus.FieldSel == FS_DAY);
  assign inc_al_min  = set_inc && bus.Target && bus.FieldSel == FS_MIN;
  assign inc_al_hour = set_inc && bus.Target && bus.FieldSel == FS_HOUR;

  mod_n_counter #(.N(SEC_MAX + 1), .WIDTH(6)) u_sec (
    .Clk(Clk), .Reset(Reset), .inc(sec_inc), .clr(bus.ClearSec),
    .value(sec_q), .wrap(sec_wrap)
  );

  mod_n_counter #(.N(MIN_MAX + 1), .WIDTH(6)) u_min (
    .Clk(Clk), .Reset(Reset), .inc(inc_min), .clr(1'b0),
    .value(min_q), .wrap(min_wrap)
  );

  mod_n_counter #(.N(HOUR_MAX + 1), .WIDTH(5)) u_hour (
    .Clk(Clk), .Reset(Reset), .inc(inc_hour), .clr(1'b0),
    .value(hour_q), .wrap(hour_wrap)
  );

  mod_n_counter #(.N(DAY_MAX + 1), .WIDTH(3)) u_day (
    .Clk(Clk), .Reset(Reset), .inc(inc_day), .clr(1'b0),
    .value(day_q), .wrap(unused_day_wrap)
  );

  mod_n_counter #(.N(MIN_MAX + 1), .WIDTH(6)) u_al_min (
    .Clk(Clk), .Reset(Reset), .inc(inc_al_min), .clr(1'b0),
    .value(al_min_q), .wrap(unused_al_min_wrap)
  );

  mod_n_counter #(.N(HOUR_MAX + 1), .WIDTH(5)) u_al_hour (
    .Clk(Clk), .Reset(Reset), .inc(inc_al_hour), .clr(1'b0),
    .value(al_hour_q), .wrap(unused_al_hour_wrap)
  );

  // Compare against the post-rollover time so the match belongs to the rollover edge.
  assign min_next  = min_wrap ? '0 : min_q + 6'd1;
  assign hour_next = hour_wrap ? '0 : (min_wrap ? hour_q + 5'd1 : hour_q);
  assign match_d   = sec_wrap && bus.AlarmEn
                   && (min_next == al_min_q) && (hour_next == al_hour_q);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    if (!bus.AlarmEn) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (match_q) begin
            state_d    = ST_RING;
            ring_cnt_d = '0;
          end
        end
        ST_RING: begin
          if (bus.AlarmAck) begin
            state_d = ST_IDLE;
          end else if (bus.Snooze) begin
            state_d   = ST_SNOOZE;
            snz_cnt_d = '0;
          end else if (bus.Tick) begin
            ring_cnt_d = ring_cnt_q + 8'd1;
            if (ring_cnt_d == RING_LAST) begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_SNOOZE: begin
          if (bus.AlarmAck) begin
            state_d = ST_IDLE;
          end else if (sec_wrap) begin
            snz_cnt_d = snz_cnt_q + 4'd1;
            if (snz_cnt_d == SNOOZE_LAST) begin
              state_d    = ST_RING;
              ring_cnt_d = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ring     = 1'b0;
    snoozing = 1'b0;
    case (state_q)
      ST_RING:   ring     = 1'b1;
      ST_SNOOZE: snoozing = 1'b1;
      default: ;
    endcase
  end

  assign bus.Sec      = sec_q;
  assign bus.Min      = min_q;
  assign bus.Hour     = hour_q;
  assign bus.Day      = day_q;
  assign bus.AlMin    = al_min_q;
  assign bus.AlHour   = al_hour_q;
  assign bus.Ring     = ring;
  assign bus.Snoozing = snoozing;

endmodule

// File: tb/tb_time_alarm_datapath.sv
// Bench for time_alarm_datapath: directed scenarios plus random traffic against a week-seconds model.
module tb_time_alarm_datapath;

  localparam int RING_SECS  = 60;
  localparam int SNOOZE_MIN = 5;
  localparam int WEEK       = 7 * 86400;
  localparam int QUIET      = 0;
  localparam int RINGING    = 1;
  localparam int SNOOZING   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  time_alarm_datapath_if bus ();

  time_alarm_datapath #(.RING_SECS(RING_SECS), .SNOOZE_MIN(SNOOZE_MIN)) dut (
    .Clk(clk), .Reset(rst), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: time as seconds into the week, alarm as plain numbers.
  int m_t = 0;
  int m_amin = 0;
  int m_ahour = 0;
  int m_mode = QUIET;
  int m_ring = 0;
  int m_snz = 0;
  bit m_match = 0;

  function automatic int f_sec();  return m_t % 60;          endfunction
  function automatic int f_min();  return (m_t / 60) % 60;   endfunction
  function automatic int f_hour(); return (m_t / 3600) % 24; endfunction
  function automatic int f_day();  return m_t / 86400;       endfunction

  function automatic void model_edge();
    int s, mi, h, d, tot;
    bit minute_evt;
    if (rst) begin
      m_t = 0; m_amin = 0; m_ahour = 0; m_mode = QUIET;
      m_ring = 0; m_snz = 0; m_match = 0;
      return;
    end
    s = f_sec(); mi = f_min(); h = f_hour(); d = f_day();
    minute_evt = bus.Tick && !bus.SetMode && !bus.ClearSec && s == 59;
    if (!bus.AlarmEn) m_mode = QUIET;
    else if (m_mode == QUIET) begin
      if (m_match) begin m_mode = RINGING; m_ring = 0; end
    end else if (m_mode == RINGING) begin
      if (bus.AlarmAck) m_mode = QUIET;
      else if (bus.Snooze) begin m_mode = SNOOZING; m_snz = 0; end
      else if (bus.Tick) begin
        m_ring++;
        if (m_ring == RING_SECS) m_mode = QUIET;
      end
    end else begin
      if (bus.AlarmAck) m_mode = QUIET;
      else if (minute_evt) begin
        m_snz++;
        if (m_snz == SNOOZE_MIN) begin m_mode = RINGING; m_ring = 0; end
      end
    end
    if (bus.ClearSec) s = 0;
    else if (bus.Tick && !bus.SetMode) begin
      tot = (m_t + 1) % WEEK;
      s = tot % 60; mi = (tot / 60) % 60; h = (tot / 3600) % 24; d = tot / 86400;
    end
    if (bus.SetMode && bus.Incr) begin
      if (!bus.Target) begin
        case (bus.FieldSel)
          2'b00: mi = (mi + 1) % 60;
          2'b01: h = (h + 1) % 24;
          2'b10: d = (d + 1) % 7;
          default: ;
        endcase
      end else begin
        case (bus.FieldSel)
          2'b00: m_amin = (m_amin + 1) % 60;
          2'b01: m_ahour = (m_ahour + 1) % 24;
          default: ;
        endcase
      end
    end
    m_t = ((d * 24 + h) * 60 + mi) * 60 + s;
    m_match = minute_evt && bus.AlarmEn && mi == m_amin && h == m_ahour;
  endfunction

  function automatic logic [32:0] model_vec();
    return {3'(f_day()), 5'(f_hour()), 6'(f_min()), 6'(f_sec()),
            5'(m_ahour), 6'(m_amin), m_mode == RINGING, m_mode == SNOOZING};
  endfunction

  function automatic logic [32:0] dut_vec();
    return {bus.Day, bus.Hour, bus.Min, bus.Sec, bus.AlHour, bus.AlMin, bus.Ring, bus.Snoozing};
  endfunction

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.Tick = 0; bus.SetMode = 0; bus.Incr = 0; bus.FieldSel = 2'b11; bus.Target = 0;
    bus.ClearSec = 0; bus.AlarmEn = 0; bus.AlarmAck = 0; bus.Snooze = 0;
  endtask

  task automatic reset_dut();
    drive_idle();
    rst = 1; cycle(); cycle(); rst = 0;
  endtask

  task automatic tick_once();
    bus.Tick = 1; cycle(); bus.Tick = 0;
  endtask

  task automatic set_time(int d, int h, int mi, int s);
    bus.SetMode = 0; bus.ClearSec = 1; cycle(); bus.ClearSec = 0;
    for (int i = 0; i < s; i++) tick_once();
    bus.SetMode = 1; bus.Target = 0;
    bus.FieldSel = 2'b00;
    for (int i = 0; i < 60 && f_min() != mi; i++) begin bus.Incr = 1; cycle(); bus.Incr = 0; end
    bus.FieldSel = 2'b01;
    for (int i = 0; i < 24 && f_hour() != h; i++) begin bus.Incr = 1; cycle(); bus.Incr = 0; end
    bus.FieldSel = 2'b10;
    for (int i = 0; i < 7 && f_day() != d; i++) begin bus.Incr = 1; cycle(); bus.Incr = 0; end
    bus.SetMode = 0; bus.FieldSel = 2'b11;
  endtask

  task automatic set_alarm(int h, int mi);
    bus.SetMode = 1; bus.Target = 1;
    bus.FieldSel = 2'b00;
    for (int i = 0; i < 60 && m_amin != mi; i++) begin bus.Incr = 1; cycle(); bus.Incr = 0; end
    bus.FieldSel = 2'b01;
    for (int i = 0; i < 24 && m_ahour != h; i++) begin bus.Incr = 1; cycle(); bus.Incr = 0; end
    bus.SetMode = 0; bus.Target = 0; bus.FieldSel = 2'b11;
  endtask

  // Alarm must already be 07:30; leaves the DUT one cycle after the match edge.
  task automatic ring_now();
    set_time(0, 7, 29, 59);
    bus.AlarmEn = 1;
    tick_once();
    cycle();
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if (dut_vec() !== 33'd0) begin
      failures++; $display("FAIL reset_state: dut=%h expected=%h", dut_vec(), 33'd0);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      failures++; $display("FAIL reset_model: dut=%h model=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_carry();
    set_time(6, 23, 59, 58);
    bus.AlarmEn = 0;
    tick_once();
    checks++;
    if ({bus.Day, bus.Hour, bus.Min, bus.Sec} !== {3'd6, 5'd23, 6'd59, 6'd59}) begin
      failures++; $display("FAIL carry_59: dut=%0d %0d:%0d:%0d expected=6 23:59:59",
                           bus.Day, bus.Hour, bus.Min, bus.Sec);
    end
    tick_once();
    checks++;
    if ({bus.Day, bus.Hour, bus.Min, bus.Sec, bus.Ring} !== 21'd0) begin
      failures++; $display("FAIL carry_full: dut=%0d %0d:%0d:%0d ring=%0b expected=0 00:00:00 ring=0",
                           bus.Day, bus.Hour, bus.Min, bus.Sec, bus.Ring);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      failures++; $display("FAIL carry_model: dut=%h model=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_set_mode();
    set_time(0, 3, 59, 10);
    bus.SetMode = 1; bus.Target = 0; bus.FieldSel = 2'b00;
    bus.Incr = 1; cycle(); bus.Incr = 0;
    checks++;
    if ({bus.Hour, bus.Min} !== {5'd3, 6'd0}) begin
      failures++; $display("FAIL set_min_wrap: dut=%0d:%0d expected=3:0", bus.Hour, bus.Min);
    end
    for (int i = 0; i < 3; i++) tick_once();
    checks++;
    if (bus.Sec !== 6'd10) begin
      failures++; $display("FAIL set_tick_frozen: dut=%0d expected=10", bus.Sec);
    end
    bus.FieldSel = 2'b11; bus.Incr = 1; cycle(); bus.Incr = 0;
    bus.Target = 1; bus.FieldSel = 2'b10; bus.Incr = 1; cycle(); bus.Incr = 0;
    checks++;
    if (dut_vec() !== model_vec()) begin
      failures++; $display("FAIL set_noop: dut=%h model=%h", dut_vec(), model_vec());
    end
    bus.SetMode = 0; bus.Target = 0; bus.FieldSel = 2'b00;
    bus.Incr = 1; cycle(); bus.Incr = 0;
    checks++;
    if ({bus.Hour, bus.Min, bus.Sec} !== {5'd3, 6'd0, 6'd10}) begin
      failures++; $display("FAIL run_incr_ignored: dut=%0d:%0d:%0d expected=3:0:10",
                           bus.Hour, bus.Min, bus.Sec);
    end
    set_time(2, 23, 10, 0);
    bus.SetMode = 1; bus.FieldSel = 2'b01; bus.Incr = 1; cycle(); bus.Incr = 0;
    bus.SetMode = 0;
    checks++;
    if ({bus.Day, bus.Hour} !== {3'd2, 5'd0}) begin
      failures++; $display("FAIL set_hour_wrap: dut=day%0d hour%0d expected=day2 hour0", bus.Day, bus.Hour);
    end
  endtask

  task automatic test_clear_sec();
    set_time(0, 1, 5, 59);
    bus.ClearSec = 1; bus.Tick = 1; cycle(); bus.ClearSec = 0; bus.Tick = 0;
    checks++;
    if ({bus.Min, bus.Sec} !== {6'd5, 6'd0}) begin
      failures++; $display("FAIL clear_vs_tick: dut=%0d:%0d expected=5:0", bus.Min, bus.Sec);
    end
  endtask

  task automatic test_alarm();
    bus.AlarmEn = 0;
    set_alarm(7, 30);
    set_time(0, 7, 29, 59);
    bus.AlarmEn = 1;
    tick_once();
    checks++;
    if ({bus.Min, bus.Sec, bus.Ring} !== {6'd30, 6'd0, 1'b0}) begin
      failures++; $display("FAIL match_edge: dut=min%0d sec%0d ring%0b expected=min30 sec0 ring0",
                           bus.Min, bus.Sec, bus.Ring);
    end
    cycle();
    checks++;
    if (bus.Ring !== 1'b1) begin
      failures++; $display("FAIL ring_rise: dut=%0b expected=1", bus.Ring);
    end
    for (int i = 0; i < RING_SECS; i++) begin
      tick_once();
      if (i == RING_SECS - 2) begin
        checks++;
        if (bus.Ring !== 1'b1) begin
          failures++; $display("FAIL ring_hold: dut=%0b expected=1", bus.Ring);
        end
      end
    end
    checks++;
    if (bus.Ring !== 1'b0 || dut_vec() !== model_vec()) begin
      failures++; $display("FAIL ring_timeout: dut=%h model=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_snooze();
    ring_now();
    bus.Snooze = 1; cycle(); bus.Snooze = 0;
    checks++;
    if ({bus.Ring, bus.Snoozing} !== 2'b01) begin
      failures++; $display("FAIL snooze_enter: dut=ring%0b snz%0b expected=ring0 snz1", bus.Ring, bus.Snoozing);
    end
    for (int i = 0; i < SNOOZE_MIN * 60; i++) begin
      bus.Tick = 1; cycle();
      if (i == SNOOZE_MIN * 60 - 2) begin
        checks++;
        if ({bus.Ring, bus.Snoozing} !== 2'b01) begin
          failures++; $display("FAIL snooze_hold: dut=ring%0b snz%0b expected=ring0 snz1", bus.Ring, bus.Snoozing);
        end
      end
    end
    bus.Tick = 0;
    checks++;
    if ({bus.Ring, bus.Snoozing} !== 2'b10) begin
      failures++; $display("FAIL snooze_rering: dut=ring%0b snz%0b expected=ring1 snz0", bus.Ring, bus.Snoozing);
    end
    bus.AlarmAck = 1; cycle(); bus.AlarmAck = 0;
    checks++;
    if ({bus.Ring, bus.Snoozing} !== 2'b00 || dut_vec() !== model_vec()) begin
      failures++; $display("FAIL ack_idle: dut=%h model=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_reset_mid();
    ring_now();
    bus.Snooze = 1; cycle(); bus.Snooze = 0;
    rst = 1; cycle(); rst = 0;
    checks++;
    if (dut_vec() !== 33'd0) begin
      failures++; $display("FAIL reset_in_snooze: dut=%h expected=%h", dut_vec(), 33'd0);
    end
  endtask

  task automatic test_alarm_en_drop();
    set_alarm(7, 30);
    ring_now();
    checks++;
    if (bus.Ring !== 1'b1) begin
      failures++; $display("FAIL en_drop_ring: dut=%0b expected=1", bus.Ring);
    end
    bus.AlarmEn = 0; cycle(); bus.AlarmEn = 1;
    checks++;
    if (bus.Ring !== 1'b0) begin
      failures++; $display("FAIL en_drop_stop: dut=%0b expected=0", bus.Ring);
    end
  endtask

  task automatic test_alarm_edit();
    ring_now();
    bus.SetMode = 1; bus.Target = 1; bus.FieldSel = 2'b00;
    bus.Incr = 1; cycle(); bus.Incr = 0;
    bus.SetMode = 0; bus.Target = 0;
    checks++;
    if ({bus.AlHour, bus.AlMin, bus.Ring} !== {5'd7, 6'd31, 1'b1}) begin
      failures++; $display("FAIL edit_while_ring: dut=%0d:%0d ring%0b expected=7:31 ring1",
                           bus.AlHour, bus.AlMin, bus.Ring);
    end
    bus.AlarmAck = 1; bus.Snooze = 1; cycle(); bus.AlarmAck = 0; bus.Snooze = 0;
    checks++;
    if ({bus.Ring, bus.Snoozing} !== 2'b00) begin
      failures++; $display("FAIL ack_beats_snooze: dut=ring%0b snz%0b expected=00", bus.Ring, bus.Snoozing);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    reset_dut();
    set_alarm(0, 2);
    set_time(0, 0, 1, 30);
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 499) == 0);
      bus.SetMode  = ($urandom_range(0, 9) == 0);
      bus.Incr     = ($urandom_range(0, 3) == 0);
      bus.FieldSel = 2'($urandom_range(0, 3));
      bus.Target   = ($urandom_range(0, 1) == 1);
      bus.ClearSec = ($urandom_range(0, 39) == 0);
      bus.Tick     = ($urandom_range(0, 1) == 1);
      bus.AlarmEn  = ($urandom_range(0, 19) != 0);
      bus.AlarmAck = ($urandom_range(0, 59) == 0);
      bus.Snooze   = ($urandom_range(0, 29) == 0);
      cycle();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        if (errs < 10) $display("FAIL random_cycle_%0d: dut=%h model=%h", i, dut_vec(), model_vec());
        errs++;
      end
    end
    rst = 0;
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_carry();
    test_set_mode();
    test_clear_sec();
    test_alarm();
    test_snooze();
    test_reset_mid();
    test_alarm_en_drop();
    test_alarm_edit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/time_alarm_datapath.md
Name: time_alarm_datapath

Overview:
Datapath stage directly downstream of control_unit_1. Holds the running time of day (sec/min/hour/day) and the alarm time (min/hour), and applies the field-increment and clear commands from control. Compares time against the alarm and runs the ring/snooze state machine. Its outputs feed the display mux and the buzzer driver.

Parameters:
RING_SECS, 60, seconds Ring stays high with no Ack before it auto-stops (1..255)
SNOOZE_MIN, 5, minute rollovers spent in SNOOZE before ringing again (1..15)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Tick  in  1  one-cycle 1 Hz enable from the prescaler
SetMode  in  1  1 = setting in progress; time counters frozen
Incr  in  1  one-cycle pulse; increment the selected field
FieldSel  in  2  00 min, 01 hour, 10 day, 11 none
Target  in  1  0 = time registers, 1 = alarm registers
ClearSec  in  1  zero the seconds counter
AlarmEn  in  1  alarm armed
AlarmAck  in  1  one-cycle pulse; stop the alarm
Snooze  in  1  one-cycle pulse; snooze the alarm
Sec  out  6  seconds 0..59
Min  out  6  minutes 0..59
Hour  out  5  hours 0..23
Day  out  3  day 0..6, 0 = Sunday
AlMin  out  6  alarm minutes 0..59
AlHour  out  5  alarm hours 0..23
Ring  out  1  buzzer enable
Snoozing  out  1  1 while in SNOOZE

Behaviour:
- Reset (synchronous, Clk edge with Reset=1): every output is 0, the FSM goes to IDLE, and the internal ring/snooze counters are 0. Reset overrides all other inputs, including in the middle of RING or SNOOZE.
- Run mode (SetMode=0): on each Tick, Sec increments.
  - Sec 59->0 carries into Min.
  - Min 59->0 carries into Hour.
  - Hour 23->0 carries into Day.
  - Day 6->0 wraps.
  - A full carry chain (6 23:59:59 -> 0 00:00:00) completes in one edge.
- Set mode (SetMode=1): Tick is ignored and time is frozen. Incr adds 1 to the field chosen by FieldSel/Target.
  - The field wraps at its maximum and never carries into the next field.
  - FieldSel=11, or Target=1 with FieldSel=10, makes Incr a no-op.
  - Incr while SetMode=0 is ignored.
- ClearSec: sets Sec to 0 at the next edge, in either mode. It takes priority over a coincident Tick, and that Tick produces no minute carry.
- Match event: on a Tick edge where Sec rolls 59->0 and the new Min/Hour equal AlMin/AlHour, provided AlarmEn=1 and SetMode=0. The match is registered, so Ring rises one cycle after that Tick edge.
- FSM (states IDLE, RING, SNOOZE; encodings in the package):
  - IDLE -> RING on a match. The ring-seconds counter loads 0.
  - RING:
    - AlarmAck goes to IDLE.
    - Snooze goes to SNOOZE and loads the snooze counter with 0.
    - Otherwise each Tick increments the ring counter; reaching RING_SECS goes to IDLE.
    - Ack and Snooze together: Ack wins.
  - SNOOZE: each minute carry increments the snooze counter. Reaching SNOOZE_MIN goes to RING and the ring counter reloads 0. AlarmAck goes to IDLE.
  - AlarmEn=0 forces IDLE from any state at the next edge.
  - A match while in RING or SNOOZE is ignored.
- Outputs: Ring=1 only in RING; Snoozing=1 only in SNOOZE. All outputs are registered; there are no combinational input-to-output paths.
- Changing the alarm while ringing (Incr, Target=1, SetMode=1) updates AlMin/AlHour and does not affect the current ring.

Decomposition:
- Package alarm_clock_pkg holds:
  - FieldSel encodings (FS_MIN, FS_HOUR, FS_DAY, FS_NONE);
  - limits SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, DAY_MAX=6;
  - the 2-bit FSM state typedef (ST_IDLE, ST_RING, ST_SNOOZE).
- Sub-module mod_n_counter (parameters N and WIDTH): inputs Clk, Reset, inc, clr; outputs value and a one-cycle wrap/carry pulse. Instantiated for sec, min, hour, day, AlMin and AlHour. The carry output is not connected for the alarm registers.

Test Plan:
- Reset, then time set to 6 23:59:58, SetMode=0, 2 Ticks -> 6 23:59:59, then 0 00:00:00. Ring stays 0 because AlarmEn=0.
- SetMode=1, Target=0, FieldSel=00, Min=59, Incr -> Min=0 and Hour unchanged. Tick pulses during set mode leave Sec unchanged.
- ClearSec and Tick in the same cycle with Sec=59 -> Sec=0 and Min not incremented.
- Alarm 07:30, AlarmEn=1, time 07:29:59, Tick -> Min=30 at that edge and Ring=1 one cycle later. No Ack: Ring=0 after 60 more Ticks (RING_SECS=60).
- During RING, Snooze -> Ring=0, Snoozing=1. After 5 minute carries -> Ring=1 again. Then AlarmAck -> IDLE, with Ring=0 and Snoozing=0.
- Reset asserted during SNOOZE -> all outputs 0 next edge. AlarmEn dropped during RING -> Ring=0 next edge.
